uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//   RS-232 serial transmitter, 8 data bits, optional parity, 1 stop bit, LSB first.
//   Consumes one byte per one-cycle send pulse from the memory-dump sender FSM.
//   Drives the TXD pin, and returns a one-cycle done pulse when the frame has left the line.
//   Single clock domain; the baud timing comes from a clock-cycle divider, not a separate clock.
// PARAMETERS
//   CLKS_PER_BIT  434  clock cycles per bit (50 MHz / 115200). Must be >= 2.
//   PARITY        0    0 = none, 1 = even, 2 = odd; 3 is treated as 0.
// PORTS
//   iClock    in   1  system clock; all state updates on the rising edge
//   iReset_n  in   1  reset, asynchronous, active-low
//   iData     in   8  byte to send; sampled only on an accepted iTxSend
//   iTxSend   in   1  send request; one-cycle pulse expected, level also tolerated
//   oTx       out  1  serial line; idle high; registered
//   oTxDone   out  1  one-cycle pulse when the stop bit has completed
//   oBusy     out  1  high from the cycle after acceptance through the oTxDone cycle
// BEHAVIOUR
//   Reset: asserting iReset_n=0 immediately forces the following values, with no clock needed:
//     - oTx=1, oTxDone=0, oBusy=0
//     - state=IDLE, bit counter=0, baud counter=0
//   Reset mid-frame: the frame is aborted, no oTxDone is issued, and the line returns to idle high.
//   States: IDLE, START, DATA, PARITY, STOP, DONE (3-bit encoding).
//   IDLE:
//     - oTx=1.
//     - If iTxSend=1 at edge N: latch iData into the shift register and compute parity from iData.
//     - At edge N, go to START and clear the baud counter.
//     - oTx=0 and oBusy=1 are visible from edge N+1.
//   START:
//     - Hold oTx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
//   DATA:
//     - oTx=shift[idx], held for CLKS_PER_BIT cycles per bit, idx counting 0..7.
//     - After idx 7: go to PARITY if PARITY is 1 or 2, else to STOP.
//   PARITY:
//     - oTx = ^data for even parity, or ~^data for odd parity.
//     - Held for CLKS_PER_BIT cycles, then go to STOP.
//   STOP:
//     - oTx=1 for CLKS_PER_BIT cycles, then go to DONE.
//   DONE:
//     - oTxDone=1 and oBusy=1 for exactly one cycle, then go to IDLE.
//   Baud counter:
//     - Width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
//     - No bit period is shortened or stretched; every bit lasts exactly CLKS_PER_BIT cycles.
//   Frame length: 10*CLKS_PER_BIT line cycles without parity, 11*CLKS_PER_BIT with parity.
//     - oTxDone is asserted on line cycle 10*CLKS_PER_BIT (or 11*) after edge N+1, counting from 0.
//   iTxSend outside IDLE, including DONE, is ignored.
//     - The held byte is never modified during a frame.
//   iTxSend held high: a new frame is accepted on the first IDLE cycle after DONE.
//     - Back-to-back frames are therefore separated by exactly 1 idle-high cycle.
//   iData changing after acceptance has no effect on the frame.
//   Illegal state encodings go to IDLE with oTx=1 on the next edge.
// TESTING
//   1. CLKS_PER_BIT=4, PARITY=0, send 8'hA5.
//      -> oTx bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles.
//      -> oTxDone pulses 40 cycles after the start edge, then oBusy=0.
//   2. PARITY=1, send 8'h07 -> parity bit 1; PARITY=2, send 8'h07 -> parity bit 0.
//      -> oTxDone arrives at 44 cycles in both cases.
//   3. Pulse iTxSend with 8'h3C during DATA of a frame carrying 8'hFF.
//      -> Only 8'hFF is sent; exactly one oTxDone pulse.
//   4. Hold iTxSend=1 with iData 8'h01 then 8'h02.
//      -> Two frames separated by 1 idle cycle, each carrying the byte sampled at its own acceptance.
//   5. Pull iReset_n low mid-DATA.
//      -> oTx=1 and oBusy=0 immediately; no oTxDone.
//      -> After release, a send of 8'h55 produces a clean, complete frame.
//   6. Model of the upstream sender: 4 bytes, each sent on iTxSend, with oTxDone waited for.
//      -> A UART receiver model decodes the 4 bytes in order with no framing errors.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: RS-232 transmitter, 8 data bits, optional parity, 1 stop bit, LSB first.
// The baud rate is derived from a clock-cycle divider rather than from a separate clock.
//   iClock    system clock, rising-edge active
//   iReset_n  asynchronous active-low reset
//   iData     byte to send, sampled only when iTxSend is accepted in IDLE
//   iTxSend   send request (pulse or level)
//   oTx       serial line, idle high (registered)
//   oTxDone   one-cycle pulse once the stop bit has completed (registered)
//   oBusy     high from the cycle after acceptance through the oTxDone cycle (registered)
module uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned PARITY       = 0
) (
   input  logic       iClock,
   input  logic       iReset_n,
   input  logic [7:0] iData,
   input  logic       iTxSend,
   output logic       oTx,
   output logic       oTxDone,
   output logic       oBusy
);

   localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam bit PAR_EN  = (PARITY == 1) || (PARITY == 2);
   localparam bit PAR_ODD = (PARITY == 2);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PAR    = 3'd3,
      STOP   = 3'd4,
      DONE   = 3'd5
   } tState;

   tState             state,     stateNext;
   logic [BAUD_W-1:0] baudCnt,   baudCntNext;
   logic [2:0]        bitIdx,    bitIdxNext;
   logic [7:0]        shiftReg,  shiftRegNext;
   logic              parityBit, parityBitNext;
   logic              txNext, txDoneNext, busyNext;
   logic              baudWrap;

   // State, datapath and registered outputs
   always_ff @(posedge iClock or negedge iReset_n) begin
      if (!iReset_n) begin
         state     <= IDLE;
         baudCnt   <= '0;
         bitIdx    <= '0;
         shiftReg  <= '0;
         parityBit <= 1'b0;
         oTx       <= 1'b1;
         oTxDone   <= 1'b0;
         oBusy     <= 1'b0;
      end else begin
         state     <= stateNext;
         baudCnt   <= baudCntNext;
         bitIdx    <= bitIdxNext;
         shiftReg  <= shiftRegNext;
         parityBit <= parityBitNext;
         oTx       <= txNext;
         oTxDone   <= txDoneNext;
         oBusy     <= busyNext;
      end
   end

   // Next-state logic; output values are computed from the current state so the
   // line lags the state register by one cycle, giving every bit exactly CLKS_PER_BIT cycles.
   always_comb begin
      stateNext     = state;
      baudCntNext   = baudCnt;
      bitIdxNext    = bitIdx;
      shiftRegNext  = shiftReg;
      parityBitNext = parityBit;
      txNext        = 1'b1;
      txDoneNext    = 1'b0;
      busyNext      = 1'b1;
      baudWrap      = (baudCnt == BAUD_LAST);

      // Bit-period divider runs only while a bit is on the line
      if ((state == START) || (state == DATA) || (state == PAR) || (state == STOP)) begin
         baudCntNext = baudWrap ? '0 : baudCnt + BAUD_W'(1);
      end

      case (state)
         IDLE: begin
            busyNext = 1'b0;
            if (iTxSend) begin
               shiftRegNext  = iData;
               parityBitNext = PAR_ODD ? ~^iData : ^iData;
               baudCntNext   = '0;
               stateNext     = START;
            end
         end
         START: begin
            txNext = 1'b0;
            if (baudWrap) begin
               bitIdxNext = '0;
               stateNext  = DATA;
            end
         end
         DATA: begin
            txNext = shiftReg[bitIdx];
            if (baudWrap) begin
               if (bitIdx == 3'd7) begin
                  stateNext = PAR_EN ? PAR : STOP;
               end else begin
                  bitIdxNext = bitIdx + 3'd1;
               end
            end
         end
         PAR: begin
            txNext = parityBit;
            if (baudWrap) begin
               stateNext = STOP;
            end
         end
         STOP: begin
            if (baudWrap) begin
               stateNext = DONE;
            end
         end
         DONE: begin
            txDoneNext = 1'b1;
            stateNext  = IDLE;
         end
         default: begin
            // Unused encodings recover to idle
            busyNext    = 1'b0;
            baudCntNext = '0;
            bitIdxNext  = '0;
            stateNext   = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: three transmitters (no parity, even, odd) driven from shared stimulus,
// checked every cycle against a frame-level model, plus a line receiver on the
// no-parity instance and literal expectations for the documented examples.
module tb_uart_tx;

   localparam int C = 4;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       send  = 1'b0;
   logic [7:0] data  = 8'h00;
   logic [2:0] tx, done, busy;

   uart_tx #(.CLKS_PER_BIT(C), .PARITY(0)) u0 (
      .iClock(clk), .iReset_n(rst_n), .iData(data), .iTxSend(send),
      .oTx(tx[0]), .oTxDone(done[0]), .oBusy(busy[0]));
   uart_tx #(.CLKS_PER_BIT(C), .PARITY(1)) u1 (
      .iClock(clk), .iReset_n(rst_n), .iData(data), .iTxSend(send),
      .oTx(tx[1]), .oTxDone(done[1]), .oBusy(busy[1]));
   uart_tx #(.CLKS_PER_BIT(C), .PARITY(2)) u2 (
      .iClock(clk), .iReset_n(rst_n), .iData(data), .iTxSend(send),
      .oTx(tx[2]), .oTxDone(done[2]), .oBusy(busy[2]));

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Frame-level model: one acceptance edge and one bit vector per instance
   int         cyc = 0;
   bit         act [3];
   int         acc [3];
   logic [10:0] fb [3];

   function automatic int nbits(input int j);
      return (j == 0) ? 10 : 11;
   endfunction

   function automatic logic [10:0] frameOf(input int j, input logic [7:0] d);
      logic [10:0] f;
      int ones;
      ones = $countones(d);
      f = '1;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[i+1] = d[i];
      if (j == 1) f[9] = (ones % 2 == 1);
      else if (j == 2) f[9] = (ones % 2 == 0);
      return f;
   endfunction

   always @(posedge clk) begin
      cyc = cyc + 1;
      for (int j = 0; j < 3; j++) begin
         if (!rst_n) begin
            act[j] = 1'b0;
         end else if (send && (!act[j] || cyc >= acc[j] + nbits(j) * C + 2)) begin
            act[j] = 1'b1;
            acc[j] = cyc;
            fb[j]  = frameOf(j, data);
         end
      end
   end

   // Per-cycle compare against the model
   always @(negedge clk) begin
      for (int j = 0; j < 3; j++) begin
         logic et, eb, ed;
         int   L, n;
         et = 1'b1; eb = 1'b0; ed = 1'b0;
         if (rst_n && act[j]) begin
            n = nbits(j) * C;
            L = cyc - acc[j] - 1;
            if (L >= 0 && L < n) begin
               et = fb[j][L / C];
               eb = 1'b1;
            end else if (L == n) begin
               eb = 1'b1;
               ed = 1'b1;
            end
         end
         chk($sformatf("tx%0d@%0d", j, cyc),   32'(tx[j]),   32'(et));
         chk($sformatf("busy%0d@%0d", j, cyc), 32'(busy[j]), 32'(eb));
         chk($sformatf("done%0d@%0d", j, cyc), 32'(done[j]), 32'(ed));
      end
   end

   // Line receiver on the no-parity instance, sampling mid-bit
   int         rxCnt = -1;
   logic [9:0] rxSh;
   logic [7:0] rxQ [$];
   int         frameErr = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         rxCnt = -1;
      end else if (rxCnt < 0) begin
         if (tx[0] === 1'b0) rxCnt = 0;
      end else begin
         rxCnt++;
      end
      if (rxCnt >= 0 && (rxCnt % C) == C / 2) begin
         rxSh[rxCnt / C] = tx[0];
         if (rxCnt / C == 9) begin
            if (rxSh[9] !== 1'b1 || rxSh[0] !== 1'b0) frameErr++;
            rxQ.push_back(rxSh[8:1]);
            rxCnt = -1;
         end
      end
   end

   int doneCnt [3];
   always @(negedge clk) begin
      for (int j = 0; j < 3; j++) if (done[j] === 1'b1) doneCnt[j]++;
   end

   int          tDone   [3];
   logic [10:0] capBits [3];
   int          base    [3];

   task automatic waitIdle(input string nm);
      int k;
      k = 0;
      while (busy !== 3'b000 && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (k >= 200) chk({nm, "_timeout"}, 32'(busy), 32'd0);
      @(negedge clk);
   endtask

   // Send one byte and record, per instance, the line cycle of oTxDone and mid-bit samples
   task automatic sendTimed(input logic [7:0] d);
      for (int j = 0; j < 3; j++) begin
         tDone[j]   = -1;
         capBits[j] = 'x;
      end
      @(negedge clk); data = d; send = 1'b1;
      @(negedge clk); send = 1'b0;
      for (int k = 0; k < 60; k++) begin
         for (int j = 0; j < 3; j++) begin
            int L;
            L = k - 1;
            if (done[j] === 1'b1 && tDone[j] < 0) tDone[j] = L;
            if (L >= 0 && L < 11 * C && (L % C) == C / 2) capBits[j][L / C] = tx[j];
         end
         @(negedge clk);
      end
   endtask

   task automatic saveBase();
      for (int j = 0; j < 3; j++) base[j] = doneCnt[j];
   endtask

   task automatic waitDone(input int j, input string nm);
      int k;
      k = 0;
      while (done[j] !== 1'b1 && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (k >= 100) chk({nm, "_timeout"}, 32'(done[j]), 32'd1);
   endtask

   logic [7:0] expQ [$];
   int         rxBase;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_tx",   32'(tx),   32'h7);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic frame and completion timing
      sendTimed(8'hA5);
      chk("t1_bits",  32'(capBits[0][9:0]), 32'(10'b1101001010));
      chk("t1_done0", 32'(tDone[0]), 32'd40);
      chk("t1_done1", 32'(tDone[1]), 32'd44);
      chk("t1_done2", 32'(tDone[2]), 32'd44);
      chk("t1_busy",  32'(busy), 32'h0);

      // Parity bits
      sendTimed(8'h07);
      chk("t2_bits0",    32'(capBits[0][9:0]), 32'(10'b1000001110));
      chk("t2_par_even", 32'(capBits[1][9]), 32'd1);
      chk("t2_par_odd",  32'(capBits[2][9]), 32'd0);
      chk("t2_done1",    32'(tDone[1]), 32'd44);
      chk("t2_done2",    32'(tDone[2]), 32'd44);

      // Request during DATA is ignored
      saveBase();
      rxBase = rxQ.size();
      @(negedge clk); data = 8'hFF; send = 1'b1;
      @(negedge clk); send = 1'b0; data = 8'h00;
      repeat (10) @(negedge clk);
      data = 8'h3C; send = 1'b1;
      @(negedge clk); send = 1'b0;
      waitIdle("t3");
      repeat (4) @(negedge clk);
      for (int j = 0; j < 3; j++)
         chk($sformatf("t3_donecnt%0d", j), 32'(doneCnt[j] - base[j]), 32'd1);
      chk("t3_rxcnt", 32'(rxQ.size() - rxBase), 32'd1);
      if (rxQ.size() > 0) chk("t3_rxbyte", 32'(rxQ[rxQ.size() - 1]), 32'hFF);

      // Held request: back-to-back frames with one idle cycle between
      saveBase();
      rxBase = rxQ.size();
      @(negedge clk); data = 8'h01; send = 1'b1;
      repeat (2) @(negedge clk);
      waitDone(0, "t4_done0");
      data = 8'h02;
      @(negedge clk); chk("t4_gap_idle", 32'(busy[0]), 32'd0);
      @(negedge clk); chk("t4_gap_end",  32'(busy[0]), 32'd1);
      waitDone(2, "t4_done2");
      @(negedge clk); send = 1'b0; data = 8'hEE;
      repeat (2) @(negedge clk);
      waitIdle("t4");
      for (int j = 0; j < 3; j++)
         chk($sformatf("t4_donecnt%0d", j), 32'(doneCnt[j] - base[j]), 32'd2);
      chk("t4_rxcnt", 32'(rxQ.size() - rxBase), 32'd2);
      if (rxQ.size() >= 2) begin
         chk("t4_rx0", 32'(rxQ[rxQ.size() - 2]), 32'h01);
         chk("t4_rx1", 32'(rxQ[rxQ.size() - 1]), 32'h02);
      end

      // Reset mid-frame
      saveBase();
      rxBase = rxQ.size();
      @(negedge clk); data = 8'hC3; send = 1'b1;
      @(negedge clk); send = 1'b0;
      repeat (15) @(negedge clk);
      @(posedge clk); #2 rst_n = 1'b0; #1;
      chk("t5_tx",   32'(tx),   32'h7);
      chk("t5_busy", 32'(busy), 32'h0);
      chk("t5_done", 32'(done), 32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (60) @(negedge clk);
      for (int j = 0; j < 3; j++)
         chk($sformatf("t5_nodone%0d", j), 32'(doneCnt[j] - base[j]), 32'd0);
      chk("t5_norx", 32'(rxQ.size() - rxBase), 32'd0);
      sendTimed(8'h55);
      chk("t5_bits",  32'(capBits[0][9:0]), 32'(10'b1010101010));
      chk("t5_done0", 32'(tDone[0]), 32'd40);
      chk("t5_done2", 32'(tDone[2]), 32'd44);
      if (rxQ.size() > 0) chk("t5_rxbyte", 32'(rxQ[rxQ.size() - 1]), 32'h55);

      // Upstream sender: random bytes, random request length, data scribbled mid-frame
      rxQ.delete();
      for (int i = 0; i < 16; i++) begin
         logic [7:0] b;
         int hold;
         b    = 8'($urandom);
         hold = int'($urandom_range(1, 3));
         expQ.push_back(b);
         @(negedge clk); data = b; send = 1'b1;
         repeat (hold) @(negedge clk);
         send = 1'b0;
         data = 8'($urandom);
         @(negedge clk);
         waitIdle("t6");
         repeat (int'($urandom_range(0, 4))) @(negedge clk);
      end
      chk("t6_rxcnt", 32'(rxQ.size()), 32'(expQ.size()));
      for (int i = 0; i < expQ.size() && i < rxQ.size(); i++)
         chk($sformatf("t6_rx%0d", i), 32'(rxQ[i]), 32'(expQ[i]));
      chk("t6_framing", 32'(frameErr), 32'd0);

      repeat (4) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
